// File: rtl/fft_pkg.sv
// Shared fixed-point defaults and saturation bounds for the FFT datapath blocks.
package fft_pkg;

  localparam int Q_IN_DEF    = 15;
  localparam int Q_COEFF_DEF = 15;
  localparam int Q_OUT_DEF   = 15;

  // Largest and smallest value representable in a signed w-bit word.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/sat_trunc.sv
// Clamps a signed W_IN-bit value into a signed W_OUT-bit range and flags when it did.
module sat_trunc
  import fft_pkg::*;
#(
  parameter int W_IN  = 18,
  parameter int W_OUT = 16
) (
  input  logic signed [W_IN-1:0]  x,
  output logic signed [W_OUT-1:0] y,
  output logic                    clamped
);

  localparam longint HI = sat_max(W_OUT);
  localparam longint LO = sat_min(W_OUT);

  logic signed [63:0] xExt;

  always_comb begin
    xExt    = 64'(x);
    y       = x[W_OUT-1:0];
    clamped = 1'b0;
    if (xExt > HI) begin
      y       = W_OUT'(HI);
      clamped = 1'b1;
    end else if (xExt < LO) begin
      y       = W_OUT'(LO);
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/ifft_butterfly_unit.sv
// Three-stage pipelined inverse DIF butterfly: y0 = (a+b)/2, y1 = (a-b)*conj(W)/2,
// with a single stall enable shared by every stage and a sticky saturation flag.
module ifft_butterfly_unit
  import fft_pkg::*;
#(
  parameter int Q_IN    = Q_IN_DEF,
  parameter int Q_COEFF = Q_COEFF_DEF,
  parameter int Q_OUT   = Q_OUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic signed [Q_IN:0]  a_real,
  input  logic signed [Q_IN:0]  a_imag,
  input  logic signed [Q_IN:0]  b_real,
  input  logic signed [Q_IN:0]  b_imag,
  input  logic signed [Q_COEFF:0] W_real,
  input  logic signed [Q_COEFF:0] W_imag,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic signed [Q_OUT:0] y0_real,
  output logic signed [Q_OUT:0] y0_imag,
  output logic signed [Q_OUT:0] y1_real,
  output logic signed [Q_OUT:0] y1_imag,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int SW = Q_IN + 2;
  localparam int PW = Q_IN + Q_COEFF + 4;
  localparam int CW = Q_COEFF + 1;
  localparam int OW = Q_OUT + 1;

  logic en;

  logic                 v1_q;
  logic signed [SW-1:0] sumRe1_q, sumIm1_q, difRe1_q, difIm1_q;
  logic signed [SW-1:0] sumRe1_d, sumIm1_d, difRe1_d, difIm1_d;
  logic signed [CW-1:0] wRe1_q, wIm1_q;

  logic                 v2_q;
  logic signed [SW-1:0] sumRe2_q, sumIm2_q;
  logic signed [PW-1:0] pRe2_q, pIm2_q, pRe2_d, pIm2_d;

  logic signed [SW-1:0] y0ReSh, y0ImSh;
  logic signed [PW-1:0] y1ReSh, y1ImSh;
  logic signed [OW-1:0] y0ReSat, y0ImSat, y1ReSat, y1ImSat;
  logic                 clpY0Re, clpY0Im, clpY1Re, clpY1Im, anyClamp;

  logic                 vOut_q, ovf_q;
  logic signed [OW-1:0] y0Re_q, y0Im_q, y1Re_q, y1Im_q;

  // One enable for the whole pipe: it moves whenever the output slot is free or being taken.
  assign en       = !vOut_q || ready_out;
  assign ready_in = en;

  always_comb begin
    sumRe1_d = SW'(a_real) + SW'(b_real);
    sumIm1_d = SW'(a_imag) + SW'(b_imag);
    difRe1_d = SW'(a_real) - SW'(b_real);
    difIm1_d = SW'(a_imag) - SW'(b_imag);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1_q     <= 1'b0;
      sumRe1_q <= '0;
      sumIm1_q <= '0;
      difRe1_q <= '0;
      difIm1_q <= '0;
      wRe1_q   <= '0;
      wIm1_q   <= '0;
    end else if (en) begin
      v1_q <= valid_in;
      if (valid_in) begin
        sumRe1_q <= sumRe1_d;
        sumIm1_q <= sumIm1_d;
        difRe1_q <= difRe1_d;
        difIm1_q <= difIm1_d;
        wRe1_q   <= W_real;
        wIm1_q   <= W_imag;
      end
    end
  end

  // Multiplying by conj(W) flips the sign of the Wi cross terms.
  always_comb begin
    pRe2_d = PW'(difRe1_q) * PW'(wRe1_q) + PW'(difIm1_q) * PW'(wIm1_q);
    pIm2_d = PW'(difIm1_q) * PW'(wRe1_q) - PW'(difRe1_q) * PW'(wIm1_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v2_q     <= 1'b0;
      sumRe2_q <= '0;
      sumIm2_q <= '0;
      pRe2_q   <= '0;
      pIm2_q   <= '0;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sumRe2_q <= sumRe1_q;
        sumIm2_q <= sumIm1_q;
        pRe2_q   <= pRe2_d;
        pIm2_q   <= pIm2_d;
      end
    end
  end

  // The extra shift bit on the products folds the /2 of the butterfly into the Q rescale.
  assign y0ReSh = sumRe2_q >>> 1;
  assign y0ImSh = sumIm2_q >>> 1;
  assign y1ReSh = pRe2_q >>> CW;
  assign y1ImSh = pIm2_q >>> CW;

  sat_trunc #(.W_IN(SW), .W_OUT(OW)) u_sat_y0_re (.x(y0ReSh), .y(y0ReSat), .clamped(clpY0Re));
  sat_trunc #(.W_IN(SW), .W_OUT(OW)) u_sat_y0_im (.x(y0ImSh), .y(y0ImSat), .clamped(clpY0Im));
  sat_trunc #(.W_IN(PW), .W_OUT(OW)) u_sat_y1_re (.x(y1ReSh), .y(y1ReSat), .clamped(clpY1Re));
  sat_trunc #(.W_IN(PW), .W_OUT(OW)) u_sat_y1_im (.x(y1ImSh), .y(y1ImSat), .clamped(clpY1Im));

  assign anyClamp = clpY0Re | clpY0Im | clpY1Re | clpY1Im;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vOut_q <= 1'b0;
      y0Re_q <= '0;
      y0Im_q <= '0;
      y1Re_q <= '0;
      y1Im_q <= '0;
    end else if (en) begin
      vOut_q <= v2_q;
      if (v2_q) begin
        y0Re_q <= y0ReSat;
        y0Im_q <= y0ImSat;
        y1Re_q <= y1ReSat;
        y1Im_q <= y1ImSat;
      end
    end
  end

  // A fresh clamp outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (en && v2_q && anyClamp) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign valid_out = vOut_q;
  assign ovf       = ovf_q;
  assign y0_real   = y0Re_q;
  assign y0_imag   = y0Im_q;
  assign y1_real   = y1Re_q;
  assign y1_imag   = y1Im_q;

endmodule

// File: tb/tb_ifft_butterfly_unit.sv
// Directed bench for ifft_butterfly_unit: a vector table for arithmetic plus sequences for
// overflow stickiness, backpressure, mid-flight reset and bubble propagation.
module tb_ifft_butterfly_unit;

  localparam int Q = 15;

  logic clk = 1'b0;
  logic reset, valid_in, ready_in, valid_out, ready_out, ovf, ovf_clr;
  logic signed [Q:0] a_real, a_imag, b_real, b_imag, W_real, W_imag;
  logic signed [Q:0] y0_real, y0_imag, y1_real, y1_imag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string name;
    int ar, ai, br, bi, wr, wi;
    int y0r, y0i, y1r, y1i, ovfE;
  } vec_t;

  vec_t vecs[7];

  ifft_butterfly_unit dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .W_real(W_real), .W_imag(W_imag),
    .valid_out(valid_out), .ready_out(ready_out),
    .y0_real(y0_real), .y0_imag(y0_imag), .y1_real(y1_real), .y1_imag(y1_imag),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResult(input string tag, input int y0r, input int y0i, input int y1r, input int y1i);
    checkOutput({tag, " y0_real"}, y0_real, y0r);
    checkOutput({tag, " y0_imag"}, y0_imag, y0i);
    checkOutput({tag, " y1_real"}, y1_real, y1r);
    checkOutput({tag, " y1_imag"}, y1_imag, y1i);
  endtask

  task automatic applyStimulus(input int ar, input int ai, input int br, input int bi, input int wr, input int wi);
    a_real = (Q+1)'(ar);
    a_imag = (Q+1)'(ai);
    b_real = (Q+1)'(br);
    b_imag = (Q+1)'(bi);
    W_real = (Q+1)'(wr);
    W_imag = (Q+1)'(wi);
  endtask

  initial begin
    int got;
    bit xfer;

    vecs[0] = '{"basic",      8192,      0,   4096,      0,  32767,      0,  6144,      0,   2047,    0, 0};
    vecs[1] = '{"twiddle_j",  16384,     0,      0,      0,      0, -32768,  8192,      0,      0, 8192, 0};
    vecs[2] = '{"half_half",  -8192,  4096,   4096,  -4096,  16384,  16384, -2048,      0,  -1024, 5120, 0};
    vecs[3] = '{"floor",          1,    -1,      0,      0,  32767,      0,     0,     -1,      0,   -1, 0};
    vecs[4] = '{"y0_edges",   32767,-32768,  32767, -32768,      0,      0, 32767, -32768,      0,    0, 0};
    vecs[5] = '{"y1_neg_edge",32767,     0, -32768,      0, -32768,      0,    -1,      0, -32768,    0, 0};
    vecs[6] = '{"y1_pos_clip",-32768,-32768, 32767,  32767, -32768, -32768,    -1,     -1,  32767,    0, 1};

    reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1; ovf_clr = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step;
    step;
    checkOutput("reset valid_out", valid_out, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset ready_in", ready_in, 1);
    checkResult("reset", 0, 0, 0, 0);
    reset = 1'b1;
    step;
    checkOutput("post-reset ready_in", ready_in, 1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, vecs[i].wr, vecs[i].wi);
      valid_in = 1'b1;
      step;
      valid_in = 1'b0;
      step;
      checkOutput({vecs[i].name, " early valid_out"}, valid_out, 0);
      step;
      checkOutput({vecs[i].name, " valid_out"}, valid_out, 1);
      checkResult(vecs[i].name, vecs[i].y0r, vecs[i].y0i, vecs[i].y1r, vecs[i].y1i);
      checkOutput({vecs[i].name, " ovf"}, ovf, vecs[i].ovfE);
      if (vecs[i].ovfE != 0) begin
        ovf_clr = 1'b1;
        step;
        ovf_clr = 1'b0;
        checkOutput({vecs[i].name, " ovf cleared"}, ovf, 0);
      end
      step;
    end

    // Clamp lands in the same cycle as ovf_clr: set must win, then the flag stays sticky.
    applyStimulus(32767, 32767, -32768, -32768, -32768, -32768);
    valid_in = 1'b1;
    step;
    valid_in = 1'b0;
    step;
    ovf_clr = 1'b1;
    step;
    ovf_clr = 1'b0;
    checkOutput("neg_clip valid_out", valid_out, 1);
    checkResult("neg_clip", -1, -1, -32768, 0);
    checkOutput("neg_clip ovf set wins", ovf, 1);
    repeat (3) step;
    checkOutput("neg_clip ovf sticky", ovf, 1);
    ovf_clr = 1'b1;
    step;
    ovf_clr = 1'b0;
    checkOutput("neg_clip ovf after clear", ovf, 0);
    repeat (3) step;

    // Backpressure: four sets, output stalled for five cycles once the first result shows.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1000 * k, -500 * k, 200, 100, -32768, 0);
      valid_in = 1'b1;
      step;
    end
    applyStimulus(4000, -2000, 200, 100, -32768, 0);
    ready_out = 1'b0;
    #1;
    checkOutput("bp first valid_out", valid_out, 1);
    checkOutput("bp ready_in drops", ready_in, 0);
    for (int c = 0; c < 5; c++) begin
      step;
      checkOutput("bp stall valid_out", valid_out, 1);
      checkOutput("bp stall ready_in", ready_in, 0);
      checkResult("bp hold", 600, -200, -400, 300);
    end
    ready_out = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (valid_out) begin
        got++;
        checkResult($sformatf("bp out%0d", got), 500 * got + 100, -250 * got + 50,
                    -(500 * got - 100), 250 * got + 50);
      end
      xfer = valid_in && ready_in;
      step;
      if (xfer) valid_in = 1'b0;
    end
    checkOutput("bp result count", got, 4);
    valid_in = 1'b0;
    step;
    checkOutput("bp no duplicate", valid_out, 0);
    repeat (3) step;

    // Reset with two sets in flight while ovf is set.
    applyStimulus(-32768, -32768, 32767, 32767, -32768, -32768);
    valid_in = 1'b1;
    step;
    valid_in = 1'b0;
    step;
    step;
    checkOutput("rst pre ovf", ovf, 1);
    applyStimulus(8192, 0, 4096, 0, 32767, 0);
    valid_in = 1'b1;
    step;
    step;
    valid_in = 1'b0;
    reset = 1'b0;
    step;
    reset = 1'b1;
    checkOutput("rst valid_out", valid_out, 0);
    checkOutput("rst ovf", ovf, 0);
    checkOutput("rst ready_in", ready_in, 1);
    checkOutput("rst y0_real", y0_real, 0);
    for (int c = 0; c < 5; c++) begin
      step;
      checkOutput("rst no stale output", valid_out, 0);
    end

    // Alternating bubbles must come out with the same spacing, 3 cycles later.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(100 * i, 0, 0, 0, 0, 0);
      valid_in = ((i % 2) == 0);
      step;
      if (i >= 2) begin
        checkOutput($sformatf("alt valid_out %0d", i), valid_out, ((i - 2) % 2) == 0);
        if (((i - 2) % 2) == 0) checkOutput($sformatf("alt y0_real %0d", i), y0_real, 50 * (i - 2));
      end else begin
        checkOutput($sformatf("alt valid_out %0d", i), valid_out, 0);
      end
    end
    valid_in = 1'b0;
    repeat (3) step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifft_butterfly_unit.md
IFFT_BUTTERFLY_UNIT -- requirements
Module: ifft_butterfly_unit

Interface
REQ-001 The block SHALL have parameter Q_IN, default 15: input data and b operands are Q_IN+1 bits signed, Q1.Q_IN.
REQ-002 The block SHALL have parameter Q_COEFF, default 15: twiddle operands are Q_COEFF+1 bits signed, Q1.Q_COEFF.
REQ-003 The block SHALL have parameter Q_OUT, default 15: outputs are Q_OUT+1 bits signed, Q1.Q_OUT.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-006 The block SHALL have port valid_in, input, 1 bit: the input operand set is valid.
REQ-007 The block SHALL have port ready_in, output, 1 bit: the block accepts the input operand set this cycle.
REQ-008 The block SHALL have ports a_real, a_imag, b_real, b_imag, input, Q_IN+1 bits each: the complex operands a and b.
REQ-009 The block SHALL have ports W_real, W_imag, input, Q_COEFF+1 bits each: the forward twiddle W, captured together with a and b.
REQ-010 The block SHALL have port valid_out, output, 1 bit: the output pair is valid.
REQ-011 The block SHALL have port ready_out, input, 1 bit: downstream accepts the output pair.
REQ-012 The block SHALL have ports y0_real, y0_imag, y1_real, y1_imag, output, Q_OUT+1 bits each: the result pair.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky saturation flag.
REQ-014 The block SHALL have port ovf_clr, input, 1 bit: synchronous clear of ovf.

Function
REQ-015 The block SHALL compute the inverse (DIF) butterfly y0 = (a+b)/2 and y1 = ((a-b)*conj(W))/2.
REQ-016 The block SHALL implement a 3-stage pipeline: S1 registers sum = a+b and diff = a-b at Q_IN+2 bits with no loss.
REQ-017 S2 SHALL register pr = dr*Wr + di*Wi and pi = di*Wr - dr*Wi at full width of Q_IN+Q_COEFF+4 bits.
REQ-018 S3 SHALL compute y1 as pr and pi shifted by >>> (Q_COEFF+1), and y0 as sum >>> 1; shifts are arithmetic and truncate toward -inf; S3 saturates to Q_OUT+1 bits and registers the result to the outputs.
REQ-019 Saturation SHALL clamp each component to [-2^Q_OUT, 2^Q_OUT-1]; any clamp in a cycle where S3 loads SHALL set ovf.
REQ-020 ovf SHALL stay high until reset or ovf_clr; when ovf_clr and a new clamp occur in the same cycle, set SHALL win.
REQ-021 The enable SHALL be en = !valid_out || ready_out; all stages and their valid bits advance only when en=1.
REQ-022 ready_in SHALL equal en; a transfer occurs iff valid_in && ready_in.
REQ-023 Latency from input transfer to valid_out SHALL be 3 cycles when en is continuously high, giving throughput of 1 operand set per cycle.
REQ-024 When en=0, all stage data and outputs SHALL hold; no operand set is lost, duplicated or reordered.
REQ-025 Bubbles (valid_in=0 when en=1) SHALL propagate as invalid stages and SHALL NOT be compressed.
REQ-026 Output data SHALL change only when S3 loads a valid set.
REQ-027 Output data while valid_out=0 SHALL be don't-care to the consumer.

Reset
REQ-028 When reset=0 at a clock edge, all stage valid bits, valid_out and ovf SHALL clear to 0, and all y* and stage data registers SHALL clear to 0.
REQ-029 Reset SHALL take priority over en and ovf_clr.
REQ-030 Reset asserted mid-operation SHALL discard in-flight sets.
REQ-031 ready_in SHALL be 1 in the first cycle after reset.

Structure
REQ-032 The Q_* default constants and the saturation bounds SHALL live in the shared package fft_pkg.
REQ-033 Saturation SHALL be one sub-module, sat_trunc, parameterised by input and output width, with outputs y and clamped; it SHALL be instantiated four times.

Verification
REQ-034 Q=15, W=(32767,0), a=(8192,0), b=(4096,0) SHALL give y0=(6144,0) and y1=(2047,0) 3 cycles after transfer, with ovf=0.
REQ-035 W=(0,-32768), a=(16384,0), b=(0,0) SHALL give y0=(8192,0) and y1=(0,8192).
REQ-036 W=(-32768,-32768), a=(32767,32767), b=(-32768,-32768) SHALL give y1=(-32768,0), y0=(-1,-1) and ovf=1; ovf SHALL stay 1 until ovf_clr is pulsed, then read 0.
REQ-037 With 4 back-to-back sets sent and ready_out=0 for 5 cycles from the cycle the first result appears: ready_in SHALL drop, outputs SHALL hold, and all 4 results SHALL emerge in order once ready_out=1.
REQ-038 Driving reset=0 for 1 cycle with 2 sets in flight SHALL clear valid_out and ovf next cycle, SHALL produce no stale output afterwards, and ready_in SHALL be 1.
REQ-039 Alternating valid_in=1/0 with ready_out=1 SHALL produce valid_out alternating with the same pattern delayed 3 cycles.
